// File: rtl/shifter_left_seq.sv
// Multicycle 16-bit logical left shifter, one bit position per clock.
// Latency: shamt+1 cycles from the accepting edge to done; back-to-back every shamt+2 cycles.
// Backpressure: start is only honoured in IDLE or DONE; requests during SHIFT are dropped, never queued.
module shifter_left_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  shamt,
    input  logic [15:0] sftSrc,
    output logic [15:0] result,
    output logic        cout,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [15:0] work;
    logic [15:0] work_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        cout_q;
    logic        cout_nxt;
    logic        accept;

    assign accept = start && ((state == IDLE) || (state == DONE));

    // busy/done are registered from the next state so they stay glitch-free flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == SHIFT);
            done  <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = start ? SHIFT : IDLE;
            SHIFT:   state_nxt = (cnt == 4'd0) ? DONE : SHIFT;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        work_nxt = work;
        cnt_nxt  = cnt;
        cout_nxt = cout_q;
        if (accept) begin
            work_nxt = sftSrc;
            cnt_nxt  = shamt;
            cout_nxt = 1'b0;
        end else if ((state == SHIFT) && (cnt != 4'd0)) begin
            work_nxt = {work[14:0], 1'b0};
            cout_nxt = work[15];
            cnt_nxt  = cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work   <= 16'h0000;
            cnt    <= 4'd0;
            cout_q <= 1'b0;
        end else begin
            work   <= work_nxt;
            cnt    <= cnt_nxt;
            cout_q <= cout_nxt;
        end
    end

    assign result = work;
    assign cout   = cout_q;

endmodule

// File: tb/tb_shifter_left_seq.sv
// Directed bench for shifter_left_seq: hand-computed results, carry-out, latency and handshake.
module tb_shifter_left_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  shamt;
    logic [15:0] sftSrc;
    logic [15:0] result;
    logic        cout;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    shifter_left_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .shamt  (shamt),
        .sftSrc (sftSrc),
        .result (result),
        .cout   (cout),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] src, input logic [3:0] sh);
        sftSrc = src;
        shamt  = sh;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Counts edges after the accepting edge until done, bounded at 40.
    task automatic wait_done(output int cyc, output int bc, output int overlap);
        cyc = 0;
        bc = 0;
        overlap = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bc++;
            tick();
            cyc++;
            if (busy === 1'b1 && done === 1'b1) overlap++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; shamt = 4'd0; sftSrc = 16'h0000;
        #1 rst_n = 1'b0;
        #2;
        total++; if (result !== 16'h0000) begin bad++; $display("FAIL por_result: got %h want 0000", result); end
        total++; if ({cout, busy, done} !== 3'b000) begin bad++; $display("FAIL por_flags: got %b want 000", {cout, busy, done}); end
        tick();
        rst_n = 1'b1;
        tick();
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL idle_after_por: got %b want 00", {busy, done}); end
    endtask

    task automatic test_zero_shift();
        int cyc, bc, ov;
        launch(16'hA5A5, 4'd0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy_rise: got %b want 1", busy); end
        wait_done(cyc, bc, ov);
        total++; if (cyc != 1) begin bad++; $display("FAIL zero_latency: got %0d want 1", cyc); end
        total++; if (bc != 1) begin bad++; $display("FAIL zero_busy_len: got %0d want 1", bc); end
        total++; if (result !== 16'hA5A5 || cout !== 1'b0) begin bad++; $display("FAIL zero_value: got %h/%b want a5a5/0", result, cout); end
        tick();
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL zero_done_pulse: got %b want 00", {busy, done}); end
    endtask

    task automatic test_reset_idle();
        int cyc, bc, ov;
        rst_n = 1'b0;
        #2;
        total++; if (result !== 16'h0000) begin bad++; $display("FAIL idle_rst_result: got %h want 0000", result); end
        tick();
        // start presented together with reset release is sampled by the first edge
        sftSrc = 16'h0003; shamt = 4'd2; start = 1'b1; rst_n = 1'b1;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rel_start_accept: got %b want 1", busy); end
        wait_done(cyc, bc, ov);
        total++; if (cyc != 3) begin bad++; $display("FAIL rel_latency: got %0d want 3", cyc); end
        total++; if (result !== 16'h000C || cout !== 1'b0) begin bad++; $display("FAIL rel_value: got %h/%b want 000c/0", result, cout); end
        tick();
    endtask

    task automatic test_shift4();
        int cyc, bc, ov;
        launch(16'hF00F, 4'd4);
        wait_done(cyc, bc, ov);
        total++; if (cyc != 5) begin bad++; $display("FAIL sh4_latency: got %0d want 5", cyc); end
        total++; if (bc != 5) begin bad++; $display("FAIL sh4_busy_len: got %0d want 5", bc); end
        total++; if (ov != 0) begin bad++; $display("FAIL sh4_overlap: got %0d want 0", ov); end
        total++; if (result !== 16'h00F0 || cout !== 1'b1) begin bad++; $display("FAIL sh4_value: got %h/%b want 00f0/1", result, cout); end
        tick();
    endtask

    task automatic test_max_shift();
        int cyc, bc, ov;
        launch(16'h0001, 4'd15);
        wait_done(cyc, bc, ov);
        total++; if (cyc != 16) begin bad++; $display("FAIL max_latency: got %0d want 16", cyc); end
        total++; if (result !== 16'h8000 || cout !== 1'b0) begin bad++; $display("FAIL max_value_a: got %h/%b want 8000/0", result, cout); end
        tick();
        launch(16'h0002, 4'd15);
        wait_done(cyc, bc, ov);
        total++; if (cyc != 16) begin bad++; $display("FAIL max_latency_b: got %0d want 16", cyc); end
        total++; if (result !== 16'h0000 || cout !== 1'b1) begin bad++; $display("FAIL max_value_b: got %h/%b want 0000/1", result, cout); end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc, bc, ov;
        launch(16'h00FF, 4'd8);
        tick(); tick(); tick();
        sftSrc = 16'h1234; shamt = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc, bc, ov);
        total++; if (cyc != 5) begin bad++; $display("FAIL busy_ignore_latency: got %0d want 5", cyc); end
        total++; if (result !== 16'hFF00 || cout !== 1'b0) begin bad++; $display("FAIL busy_ignore_value: got %h/%b want ff00/0", result, cout); end
        sftSrc = 16'h1234; shamt = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL b2b_restart: got %b want 10", {busy, done}); end
        wait_done(cyc, bc, ov);
        total++; if (cyc != 9) begin bad++; $display("FAIL b2b_latency: got %0d want 9", cyc); end
        total++; if (result !== 16'h3400 || cout !== 1'b0) begin bad++; $display("FAIL b2b_value: got %h/%b want 3400/0", result, cout); end
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc, bc, ov;
        launch(16'hFFFF, 4'd10);
        tick(); tick();
        total++; if (result !== 16'hFFFC || busy !== 1'b1) begin bad++; $display("FAIL mid_progress: got %h/%b want fffc/1", result, busy); end
        rst_n = 1'b0;
        #2;
        total++; if ({result, cout, busy, done} !== 19'h0) begin bad++; $display("FAIL mid_rst_async: got %h want 00000", {result, cout, busy, done}); end
        tick();
        rst_n = 1'b1;
        tick(); tick();
        total++; if ({result, cout, busy, done} !== 19'h0) begin bad++; $display("FAIL mid_rst_idle: got %h want 00000", {result, cout, busy, done}); end
        launch(16'h8001, 4'd1);
        wait_done(cyc, bc, ov);
        total++; if (cyc != 2) begin bad++; $display("FAIL post_rst_latency: got %0d want 2", cyc); end
        total++; if (result !== 16'h0002 || cout !== 1'b1) begin bad++; $display("FAIL post_rst_value: got %h/%b want 0002/1", result, cout); end
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_shift();
        test_reset_idle();
        test_shift4();
        test_max_shift();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shifter_left_seq.md
# shifter_left_seq

Multicycle 16-bit logical left shifter. It is the left-direction counterpart of the datapath's combinational right shifter and shares the same `sftSrc`/`shamt`/`result` operand convention. It shifts one bit position per clock under a small FSM, with a start/busy/done handshake. The ALU-shifter wrapper uses it for SLL-class operations where area matters more than latency.

## Interface
Parameters: none; the width is fixed at 16 and the shift amount at 4 bits.

- `clk` input, 1 bit: the single clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request a shift. Sampled on the rising edge in IDLE or DONE; ignored otherwise.
- `shamt` input, 4 bits: shift amount, 0–15. Sampled together with `start`.
- `sftSrc` input, 16 bits: operand. Sampled together with `start`.
- `result` output, 16 bits: working register. Valid only while `done`=1. Holds its value until the next accepted `start`.
- `cout` output, 1 bit: the last bit shifted out of bit 15. It is 0 when `shamt`=0. Valid with `done`.
- `busy` output, 1 bit: high while in SHIFT.
- `done` output, 1 bit: one-cycle pulse, high while in DONE.

## Operation
- Internal state:
  - 2-bit FSM with states IDLE, SHIFT, DONE.
  - 16-bit `work` register, driven out as `result`.
  - 4-bit down-counter `cnt`.
  - `cout` register.
- Reset (asynchronous, `rst_n`=0): FSM=IDLE, `work`=0, `cnt`=0, `cout`=0, `busy`=0, `done`=0. Outputs change immediately on assertion, with no clock required.
- IDLE:
  - If `start`=1: `work`←`sftSrc`, `cnt`←`shamt`, `cout`←0, go to SHIFT.
  - If `start`=0: hold.
- SHIFT:
  - If `cnt`≠0: `work`←{`work`[14:0],1'b0}, `cout`←`work`[15], `cnt`←`cnt`−1, stay in SHIFT.
  - If `cnt`=0: go to DONE; `work` and `cout` are unchanged.
  - `start` is ignored throughout SHIFT. No queueing.
- DONE:
  - `done`=1.
  - If `start`=1: load exactly as in IDLE and go to SHIFT (back-to-back operation).
  - If `start`=0: go to IDLE.
- Arithmetic rules:
  - The shift is logical: zeros fill from the LSB and bits leaving bit 15 are discarded, except the last one, which is captured in `cout`.
  - Final values: `result` = (`sftSrc` << `shamt`) mod 2^16.
  - `cout` = `sftSrc`[16−`shamt`] for `shamt`≥1, and 0 for `shamt`=0.
- `busy` and `done` are registered decodes of the FSM state. They are never high together.
- An unreachable FSM encoding must recover to IDLE on the next edge.

## Timing
- Let E0 be the edge on which `start` is accepted. Edges E1..E_shamt perform the shifts. Edge E_(shamt+1) enters DONE.
- Latency from the accepting edge to `done` high is `shamt`+1 cycles:
  - 1 cycle for `shamt`=0.
  - 16 cycles for `shamt`=15.
- `busy` rises after E0 and falls after E_(shamt+1), when `done` rises.
- `done` is high for exactly one cycle unless a new `start` is accepted in DONE. In that case `busy` rises on the following cycle.
- Back-to-back throughput is one operation every `shamt`+2 cycles.
- `result` changes during SHIFT (intermediate values visible). Consumers must qualify it with `done`.
- Reset asserted mid-SHIFT aborts the operation. After deassertion the block sits in IDLE with all outputs 0, and the next `start` behaves normally.
- `start` changing in the same cycle as reset deassertion: the first edge with `rst_n`=1 samples `start` normally.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-idle and mid-SHIFT → `result`=0x0000, `cout`=0, `busy`=0, `done`=0, with no clock edge needed.
- **Zero shift:** `start`, `sftSrc`=0xA5A5, `shamt`=0 → `done` 1 cycle after accept, `result`=0xA5A5, `cout`=0, `busy` high for 1 cycle.
- **Shift by 4:** `sftSrc`=0xF00F, `shamt`=4 → `busy` for 5 cycles, then `done`, `result`=0x00F0, `cout`=1.
- **Maximum shift:** `sftSrc`=0x0001, `shamt`=15 → `done` 16 cycles after accept, `result`=0x8000, `cout`=0. Also `sftSrc`=0x0002, `shamt`=15 → `result`=0x0000, `cout`=1.
- **Start while busy, then back-to-back:**
  - Pulse `start` with `sftSrc`=0x1234, `shamt`=8 three cycles into a `shamt`=8 operation on 0x00FF → ignored; `result`=0xFF00, `cout`=0.
  - Then hold `start` with `sftSrc`=0x1234, `shamt`=8 during DONE → second operation starts immediately, `result`=0x3400, `cout`=0.
- **Reset mid-operation:** reset asserted 2 cycles into `shamt`=10 on 0xFFFF, then released → IDLE with all outputs 0. A new `shamt`=1 on 0x8001 gives `result`=0x0002, `cout`=1.
